pipe_ctrl: RTL

- Central stall/flush controller for the dual-issue pipeline. Drives per-stage stall bits, fetch hold and flush into every pipeline register, including ID/EX.
- Merges hazard requests from ID/EX/MEM/WB and sequences multi-cycle EX operations (mul/div) with an internal countdown.
- Registers exception/eret flushes and suppresses exceptions raised in the flush shadow.
- Runs a stall watchdog.

---
 rtl/pipe_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush controller: merges stage hazards, sequences multi-cycle EX ops,
// registers exception flushes with a shadow window, runs a stall watchdog.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned SHADOW_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT    = 1024,
  parameter int unsigned MC_W          = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            stallreq_wb_i,
  input  logic            ex_mc_start_i,
  input  logic [MC_W-1:0] ex_mc_cycles_i,
  input  logic            excp_valid_i,
  input  logic            excp_cause_i,
  input  logic [31:0]     excp_pc_i,
  output logic [3:0]      stall_o,
  output logic            fetch_stall_o,
  output logic            flush_o,
  output logic            flush_cause_o,
  output logic [31:0]     new_pc_o,
  output logic            mc_done_o,
  output logic            mc_busy_o,
  output logic            stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_flush_cnt_o
`else
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SHADOW = 2'd2
  } state_t;

  localparam logic [MC_W-1:0] MC_ZERO_C = {MC_W{1'b0}};
  localparam logic [MC_W-1:0] MC_ONE_C  = {{(MC_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]      SH_LOAD_C = 8'(SHADOW_CYCLES - 1);
  localparam logic [15:0]     WD_LIM_C  = 16'(WDOG_LIMIT);

  state_t          state_r, state_nxt_s;
  logic            excp_take_s;
  logic [7:0]      sh_cnt_r;
  logic [MC_W-1:0] mc_cnt_r;
  logic [MC_W-1:0] mc_len_s;
  logic            mc_busy_s;
  logic            mc_start_s;
  logic            in_flush_s;
  logic [3:0]      stall_s;
  logic            mc_done_s;
  logic [15:0]     wd_cnt_r;
  logic            timeout_r;
  logic            cause_r;
  logic [31:0]     pc_r;

  assign in_flush_s = (state_r == ST_FLUSH);
  assign mc_busy_s  = (mc_cnt_r != MC_ZERO_C);
  assign mc_len_s   = (ex_mc_cycles_i == MC_ZERO_C) ? MC_ONE_C : ex_mc_cycles_i;

  // Next-state logic; exceptions are only accepted in RUN
  always_comb begin
    state_nxt_s = state_r;
    excp_take_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (excp_valid_i) begin
          state_nxt_s = ST_FLUSH;
          excp_take_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (SHADOW_CYCLES == 0) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SHADOW;
        end
      end
      ST_SHADOW: begin
        if (sh_cnt_r == 8'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SHADOW;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State register, shadow countdown and captured redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_RUN;
      sh_cnt_r <= 8'd0;
      cause_r  <= 1'b0;
      pc_r     <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (in_flush_s) begin
        sh_cnt_r <= SH_LOAD_C;
      end else if ((state_r == ST_SHADOW) && (sh_cnt_r != 8'd0)) begin
        sh_cnt_r <= sh_cnt_r - 8'd1;
      end else begin
        sh_cnt_r <= sh_cnt_r;
      end
      if (excp_take_s) begin
        cause_r <= excp_cause_i;
        pc_r    <= excp_pc_i;
      end else begin
        cause_r <= cause_r;
        pc_r    <= pc_r;
      end
    end
  end

  // A start is dropped if busy, flushing, or colliding with an accepted exception
  assign mc_start_s = ex_mc_start_i && !mc_busy_s && !in_flush_s && !excp_take_s;

  // Multi-cycle countdown holds the remaining stall cycles after the start cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_cnt_r <= MC_ZERO_C;
    end else if (excp_take_s || in_flush_s) begin
      mc_cnt_r <= MC_ZERO_C;
    end else if (mc_start_s) begin
      mc_cnt_r <= mc_len_s - MC_ONE_C;
    end else if (mc_busy_s) begin
      mc_cnt_r <= mc_cnt_r - MC_ONE_C;
    end else begin
      mc_cnt_r <= mc_cnt_r;
    end
  end

  // Monotone stall encoding, highest requesting stage wins; flush forces release
  always_comb begin
    stall_s   = 4'b0000;
    mc_done_s = 1'b0;
    if (!rst || in_flush_s) begin
      stall_s   = 4'b0000;
      mc_done_s = 1'b0;
    end else begin
      mc_done_s = (mc_start_s && (mc_len_s == MC_ONE_C)) ||
                  (mc_busy_s && (mc_cnt_r == MC_ONE_C));
      if (stallreq_wb_i) begin
        stall_s = 4'b1111;
      end else if (stallreq_mem_i) begin
        stall_s = 4'b0111;
      end else if (stallreq_ex_i || mc_start_s || mc_busy_s) begin
        stall_s = 4'b0011;
      end else if (stallreq_id_i) begin
        stall_s = 4'b0001;
      end else begin
        stall_s = 4'b0000;
      end
    end
  end

  // Watchdog: counts consecutive stalled cycles, saturates at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_r  <= 16'd0;
      timeout_r <= 1'b0;
    end else if (stall_s == 4'b0000) begin
      wd_cnt_r  <= 16'd0;
      timeout_r <= timeout_r;
    end else begin
      if (wd_cnt_r != WD_LIM_C) begin
        wd_cnt_r <= wd_cnt_r + 16'd1;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      timeout_r <= timeout_r | ((wd_cnt_r + 16'd1) == WD_LIM_C);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Free-running performance counters, wrap at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      perf_stall_r <= perf_stall_r + ((stall_s != 4'b0000) ? 32'd1 : 32'd0);
      perf_flush_r <= perf_flush_r + (in_flush_s ? 32'd1 : 32'd0);
    end
  end

  assign perf_stall_cnt_o = perf_stall_r;
  assign perf_flush_cnt_o = perf_flush_r;
`else
`endif

  assign stall_o         = stall_s;
  assign fetch_stall_o   = stall_s[0];
  assign flush_o         = in_flush_s;
  assign flush_cause_o   = cause_r;
  assign new_pc_o        = pc_r;
  assign mc_done_o       = mc_done_s;
  assign mc_busy_o       = mc_busy_s && !in_flush_s;
  assign stall_timeout_o = timeout_r;

endmodule
